// File: rtl/led_tx_pkg.sv
// Shared types and sizing constants for the LED panel frame transmitter.
package led_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        STROBE
    } tx_state_t;

    localparam int NLEDS_DEF = 64;
    localparam int DIV_W     = 8;
    localparam int STB_W     = 4;

endpackage

// File: rtl/led_tx_baud.sv
// Half-period timer for dclk: one-cycle tick every CLK_DIV enabled cycles, cleared while disabled.
module led_tx_baud
    import led_tx_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_tick
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_en || r_cnt == DIV_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = i_en && (r_cnt == DIV_LAST);

endmodule

// File: rtl/led_frame_tx.sv
// LED panel link transmitter: shifts a frame MSB first on din/dclk, then pulses strobe.
// Build option LED_TX_AUTO_REFRESH_EN resends the last frame after REFRESH_CYCLES idle cycles.
module led_frame_tx
    import led_tx_pkg::*;
#(
    parameter int NLEDS         = NLEDS_DEF,
    parameter int CLK_DIV       = 4,
    parameter int STROBE_CYCLES = 2
`ifdef LED_TX_AUTO_REFRESH_EN
    ,
    parameter int REFRESH_CYCLES = 65536
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NLEDS-1:0] frame_data,
    input  logic             frame_valid,
    output logic             frame_ready,
    output logic             busy,
    output logic             done,
    output logic             din,
    output logic             dclk,
    output logic             strobe
);

    localparam int               BIT_W    = $clog2(NLEDS);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STROBE_CYCLES);

    tx_state_t        r_state, w_state_nxt;
    logic [NLEDS-1:0] r_shift, w_shift_nxt;
    logic [BIT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [STB_W-1:0] r_stb_cnt, w_stb_cnt_nxt;
    logic             r_din, w_din_nxt;
    logic             r_dclk, w_dclk_nxt;
    logic             r_strobe, w_strobe_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_ready, w_ready_nxt;

    logic             w_tick;
    logic             w_baud_en;
    logic             w_accept;
    logic             w_load;
    logic [NLEDS-1:0] w_load_data;

    assign w_baud_en = (r_state == LOW) || (r_state == HIGH);
    assign w_accept  = (r_state == IDLE) && r_ready && frame_valid;

    led_tx_baud #(
        .CLK_DIV(CLK_DIV)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_baud_en),
        .o_tick(w_tick)
    );

`ifdef LED_TX_AUTO_REFRESH_EN
    localparam int                IDLE_W    = $clog2(REFRESH_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(REFRESH_CYCLES - 1);

    logic [IDLE_W-1:0] r_idle_cnt;
    logic [NLEDS-1:0]  r_last;
    logic              r_have_last;
    logic              w_refresh;

    // A real frame request always takes priority over a refresh expiring in the same cycle.
    assign w_refresh   = (r_state == IDLE) && r_ready && r_have_last &&
                         (r_idle_cnt == IDLE_LAST) && !w_accept;
    assign w_load      = w_accept || w_refresh;
    assign w_load_data = w_accept ? frame_data : r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt  <= '0;
            r_have_last <= 1'b0;
        end else if (w_load) begin
            r_idle_cnt <= '0;
            if (w_accept) begin
                r_have_last <= 1'b1;
            end
        end else if (r_state == IDLE) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    // NOTE: the frame store has no reset; r_have_last keeps it from being used before it is written.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_last <= frame_data;
        end
    end
`else
    assign w_load      = w_accept;
    assign w_load_data = frame_data;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_stb_cnt_nxt = r_stb_cnt;
        w_din_nxt     = r_din;
        w_dclk_nxt    = r_dclk;
        w_strobe_nxt  = r_strobe;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_ready_nxt   = r_ready;
        unique case (r_state)
            IDLE: begin
                w_ready_nxt = 1'b1;
                if (w_load) begin
                    w_state_nxt   = LOW;
                    w_shift_nxt   = w_load_data;
                    w_din_nxt     = w_load_data[NLEDS-1];
                    w_bit_cnt_nxt = BIT_W'(NLEDS - 1);
                    w_ready_nxt   = 1'b0;
                    w_busy_nxt    = 1'b1;
                end
            end
            LOW: begin
                if (w_tick) begin
                    w_state_nxt = HIGH;
                    w_dclk_nxt  = 1'b1;
                end
            end
            HIGH: begin
                if (w_tick) begin
                    w_dclk_nxt = 1'b0;
                    if (r_bit_cnt == '0) begin
                        w_state_nxt   = STROBE;
                        w_din_nxt     = 1'b0;
                        w_stb_cnt_nxt = '0;
                    end else begin
                        w_state_nxt   = LOW;
                        w_bit_cnt_nxt = r_bit_cnt - 1'b1;
                        w_shift_nxt   = r_shift << 1;
                        w_din_nxt     = r_shift[NLEDS-2];
                    end
                end
            end
            STROBE: begin
                // First STROBE cycle is a settle cycle with dclk low before strobe rises.
                if (r_stb_cnt == STB_LAST) begin
                    w_state_nxt  = IDLE;
                    w_strobe_nxt = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_ready_nxt  = 1'b1;
                end else begin
                    w_stb_cnt_nxt = r_stb_cnt + 1'b1;
                    w_strobe_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_stb_cnt <= '0;
            r_din     <= 1'b0;
            r_dclk    <= 1'b0;
            r_strobe  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_stb_cnt <= w_stb_cnt_nxt;
            r_din     <= w_din_nxt;
            r_dclk    <= w_dclk_nxt;
            r_strobe  <= w_strobe_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    assign frame_ready = r_ready;
    assign busy        = r_busy;
    assign done        = r_done;
    assign din         = r_din;
    assign dclk        = r_dclk;
    assign strobe      = r_strobe;

endmodule

// File: tb/tb_led_frame_tx.sv
// Bench for led_frame_tx: four instances (CLK_DIV 1..4) observed by a behavioural panel receiver.
// Auto-refresh scenario runs only when LED_TX_AUTO_REFRESH_EN is defined.
module tb_led_frame_tx;

    localparam int N   = 64;
    localparam int NI  = 4;
    localparam int STB = 2;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] fd  [NI];
    logic         fv  [NI];
    logic         rdy [NI];
    logic         bsy [NI];
    logic         dn  [NI];
    logic         din [NI];
    logic         dclk[NI];
    logic         stb [NI];

    int total = 0;
    int bad   = 0;

    // Panel receiver model and link statistics, per instance
    logic [N-1:0] chain [NI] = '{default: '0};
    logic [N-1:0] vbuf  [NI] = '{default: '0};
    int  rises      [NI] = '{default: 0};
    int  strobes    [NI] = '{default: 0};
    int  dones      [NI] = '{default: 0};
    int  hi_run     [NI] = '{default: 0};
    int  lo_run     [NI] = '{default: 0};
    int  stb_run    [NI] = '{default: 0};
    int  timing_bad [NI] = '{default: 0};
    int  din_bad    [NI] = '{default: 0};
    int  stb_bad    [NI] = '{default: 0};
    bit  seen_fall  [NI] = '{default: 1'b0};
    logic pdclk     [NI] = '{default: 1'b0};
    logic pstb      [NI] = '{default: 1'b0};
    logic pdin      [NI] = '{default: 1'b0};
    time t_stb      [NI] = '{default: 0};

    for (genvar g = 0; g < NI; g++) begin : g_dut
        led_frame_tx #(
            .NLEDS        (N),
            .CLK_DIV      (g + 1),
            .STROBE_CYCLES(STB)
`ifdef LED_TX_AUTO_REFRESH_EN
            ,
            .REFRESH_CYCLES((g == 0) ? 100 : 65536)
`endif
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .frame_data (fd[g]),
            .frame_valid(fv[g]),
            .frame_ready(rdy[g]),
            .busy       (bsy[g]),
            .done       (dn[g]),
            .din        (din[g]),
            .dclk       (dclk[g]),
            .strobe     (stb[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (!bsy[k]) seen_fall[k] = 1'b0;
            if (dclk[k] && din[k] !== pdin[k]) din_bad[k]++;
            if (dclk[k] && !pdclk[k]) begin
                chain[k] = {chain[k][N-2:0], din[k]};
                rises[k]++;
                if (seen_fall[k] && lo_run[k] != k + 1) timing_bad[k]++;
                hi_run[k] = 1;
            end else if (dclk[k]) begin
                hi_run[k]++;
            end
            if (!dclk[k] && pdclk[k]) begin
                if (hi_run[k] != k + 1) timing_bad[k]++;
                seen_fall[k] = 1'b1;
                lo_run[k]    = 1;
            end else if (!dclk[k]) begin
                lo_run[k]++;
            end
            if (stb[k] && !pstb[k]) begin
                vbuf[k]    = chain[k];
                strobes[k]++;
                t_stb[k]   = $time;
                stb_run[k] = 1;
            end else if (stb[k]) begin
                stb_run[k]++;
            end
            if (!stb[k] && pstb[k] && stb_run[k] != STB) stb_bad[k]++;
            if (dn[k]) dones[k]++;
            pdclk[k] = dclk[k];
            pstb[k]  = stb[k];
            pdin[k]  = din[k];
        end
    end

    function automatic int exp_lat(input int div);
        return 1 + N * 2 * div;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Present a frame and hold valid until the accepting edge; returns that edge's time.
    task automatic send(input int k, input logic [N-1:0] data, output time t_acc, output bit ok);
        ok    = 1'b0;
        t_acc = 0;
        fd[k] = data;
        fv[k] = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (rdy[k]) begin
                @(posedge clk);
                t_acc = $time;
                ok    = 1'b1;
                break;
            end
            tick();
        end
        tick();
        fv[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int d0, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (dones[k] > d0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            fv[k] = 1'b0;
            fd[k] = '0;
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            for (int k = 0; k < NI; k++) begin
                total++;
                if ({rdy[k], bsy[k], dn[k], din[k], dclk[k], stb[k]} !== 6'b0) begin
                    bad++;
                    $display("FAIL reset_outputs dut%0d: got %b want 000000", k,
                             {rdy[k], bsy[k], dn[k], din[k], dclk[k], stb[k]});
                end
            end
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (rdy[1] !== 1'b0) begin
            bad++;
            $display("FAIL ready_before_edge: got %b want 0", rdy[1]);
        end
        tick();
        for (int k = 0; k < NI; k++) begin
            total++;
            if (rdy[k] !== 1'b1) begin
                bad++;
                $display("FAIL ready_after_release dut%0d: got %b want 1", k, rdy[k]);
            end
        end
        repeat (4) tick();
        total++;
        if (rises[0] + rises[1] + rises[2] + rises[3] !== 0) begin
            bad++;
            $display("FAIL idle_dclk_edges: got %0d want 0", rises[0] + rises[1] + rises[2] + rises[3]);
        end
    endtask

    task automatic test_div2_pattern();
        int k;
        logic [N-1:0] f;
        time t_acc;
        bit ok;
        int r0, s0, d0, tb0, db0, sb0, lat;
        k = 1;
        f = 64'h8000_0000_0000_0001;
        r0 = rises[k]; s0 = strobes[k]; d0 = dones[k];
        tb0 = timing_bad[k]; db0 = din_bad[k]; sb0 = stb_bad[k];
        send(k, f, t_acc, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL div2_accept: got no accept want accept"); end
        wait_done(k, d0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL div2_done: got timeout want done"); end
        total++;
        if (rises[k] - r0 !== N) begin
            bad++; $display("FAIL div2_rises: got %0d want %0d", rises[k] - r0, N);
        end
        total++;
        if (timing_bad[k] - tb0 !== 0) begin
            bad++; $display("FAIL div2_dclk_phase: got %0d bad phases want 0", timing_bad[k] - tb0);
        end
        total++;
        if (din_bad[k] - db0 !== 0) begin
            bad++; $display("FAIL div2_din_stable: got %0d changes want 0", din_bad[k] - db0);
        end
        total++;
        if (vbuf[k] !== f) begin
            bad++; $display("FAIL div2_image: got %h want %h", vbuf[k], f);
        end
        lat = int'((t_stb[k] - t_acc - 5) / 10);
        total++;
        if (lat !== exp_lat(2)) begin
            bad++; $display("FAIL div2_latency: got %0d want %0d", lat, exp_lat(2));
        end
        total++;
        if (stb_bad[k] - sb0 !== 0) begin
            bad++; $display("FAIL div2_strobe_len: got %0d bad want 0", stb_bad[k] - sb0);
        end
        repeat (3) tick();
        total++;
        if ({dones[k] - d0, strobes[k] - s0} !== {32'sd1, 32'sd1}) begin
            bad++; $display("FAIL div2_pulses: got done=%0d strobe=%0d want 1 1", dones[k] - d0, strobes[k] - s0);
        end
        total++;
        if ({bsy[k], rdy[k]} !== 2'b01) begin
            bad++; $display("FAIL div2_idle_flags: got %b want 01", {bsy[k], rdy[k]});
        end
    endtask

    task automatic test_random();
        int k;
        logic [N-1:0] f;
        time t_acc;
        bit ok, ok2;
        int d0, tb0, db0, lat;
        for (int j = 0; j < 3; j++) begin
            k = (j == 0) ? 0 : j + 1;
            tb0 = timing_bad[k];
            db0 = din_bad[k];
            for (int n = 0; n < 4; n++) begin
                f  = {$urandom, $urandom};
                d0 = dones[k];
                send(k, f, t_acc, ok);
                wait_done(k, d0, ok2);
                total++;
                if (!(ok && ok2) || vbuf[k] !== f) begin
                    bad++; $display("FAIL rand_image div%0d: got %h want %h", k + 1, vbuf[k], f);
                end
                lat = int'((t_stb[k] - t_acc - 5) / 10);
                total++;
                if (lat !== exp_lat(k + 1)) begin
                    bad++; $display("FAIL rand_latency div%0d: got %0d want %0d", k + 1, lat, exp_lat(k + 1));
                end
            end
            total++;
            if ((timing_bad[k] - tb0) + (din_bad[k] - db0) !== 0) begin
                bad++; $display("FAIL rand_timing div%0d: got %0d violations want 0", k + 1,
                                (timing_bad[k] - tb0) + (din_bad[k] - db0));
            end
        end
    endtask

    task automatic test_back_to_back();
        int k;
        logic [N-1:0] a, b;
        int s0;
        time ta, tb;
        bit ok;
        k  = 2;
        a  = {$urandom, $urandom};
        b  = ~a ^ {$urandom, 32'h0};
        s0 = strobes[k];
        fd[k] = a;
        fv[k] = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (rdy[k]) begin ok = 1'b1; break; end
            tick();
        end
        tick();
        ok = ok && bsy[k];
        for (int n = 0; n < 3000 && ok; n++) begin
            if (dn[k]) break;
            fd[k] = {$urandom, $urandom};
            tick();
        end
        total++;
        if (!(ok && dn[k] && rdy[k])) begin
            bad++; $display("FAIL b2b_ready_in_done: got done=%b ready=%b want 1 1", dn[k], rdy[k]);
        end
        ta = t_stb[k];
        fd[k] = b;
        tick();
        total++;
        if ({bsy[k], rdy[k]} !== 2'b10) begin
            bad++; $display("FAIL b2b_accept_b: got %b want 10", {bsy[k], rdy[k]});
        end
        total++;
        if (vbuf[k] !== a) begin
            bad++; $display("FAIL b2b_image_a: got %h want %h", vbuf[k], a);
        end
        fd[k] = {$urandom, $urandom};
        fv[k] = 1'b0;
        wait_done(k, dones[k], ok);
        tb = t_stb[k];
        total++;
        if (!ok || vbuf[k] !== b) begin
            bad++; $display("FAIL b2b_image_b: got %h want %h", vbuf[k], b);
        end
        total++;
        if (int'((tb - ta) / 10) !== exp_lat(3) + STB + 1 || strobes[k] - s0 !== 2) begin
            bad++; $display("FAIL b2b_gap: got %0d cycles (%0d strobes) want %0d (2 strobes)",
                            int'((tb - ta) / 10), strobes[k] - s0, exp_lat(3) + STB + 1);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        logic [N-1:0] f1, f2, f3;
        time t_acc;
        bit ok, ok2;
        int r0, s0;
        k  = 3;
        f1 = {$urandom, $urandom};
        f2 = ~f1;
        f3 = {$urandom, $urandom};
        send(k, f1, t_acc, ok);
        wait_done(k, dones[k], ok2);
        total++;
        if (!(ok && ok2) || vbuf[k] !== f1) begin
            bad++; $display("FAIL rmid_first_image: got %h want %h", vbuf[k], f1);
        end
        r0 = rises[k];
        send(k, f2, t_acc, ok);
        for (int n = 0; n < 1000 && rises[k] - r0 < 20; n++) tick();
        s0 = strobes[k];
        rst_n = 1'b0;
        #1;
        total++;
        if ({rdy[k], bsy[k], dn[k], din[k], dclk[k], stb[k]} !== 6'b0 || rises[k] - r0 !== 20) begin
            bad++; $display("FAIL rmid_async_clear: got %b after %0d bits want 000000 after 20",
                            {rdy[k], bsy[k], dn[k], din[k], dclk[k], stb[k]}, rises[k] - r0);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        total++;
        if (strobes[k] !== s0 || vbuf[k] !== f1) begin
            bad++; $display("FAIL rmid_no_strobe: got %0d strobes image %h want 0 strobes image %h",
                            strobes[k] - s0, vbuf[k], f1);
        end
        send(k, f3, t_acc, ok);
        wait_done(k, dones[k], ok2);
        total++;
        if (!(ok && ok2) || vbuf[k] !== f3) begin
            bad++; $display("FAIL rmid_next_image: got %h want %h", vbuf[k], f3);
        end
    endtask

`ifdef LED_TX_AUTO_REFRESH_EN
    task automatic test_auto_refresh();
        int k;
        logic [N-1:0] f, g;
        time t_acc, t_d;
        bit ok;
        int s0;
        k = 0;
        f = {$urandom, $urandom};
        g = ~f;
        send(k, f, t_acc, ok);
        wait_done(k, dones[k], ok);
        t_d = $time - 1;
        s0  = strobes[k];
        wait_done(k, dones[k], ok);
        total++;
        if (!ok || strobes[k] - s0 !== 1 || vbuf[k] !== f ||
            int'((t_stb[k] - t_d) / 10) !== 100 + exp_lat(1)) begin
            bad++; $display("FAIL refresh_resend: got %0d cycles image %h want %0d image %h",
                            int'((t_stb[k] - t_d) / 10), vbuf[k], 100 + exp_lat(1), f);
        end
        t_d = $time - 1;
        repeat (99) tick();
        fd[k] = g;
        fv[k] = 1'b1;
        tick();
        fv[k] = 1'b0;
        wait_done(k, dones[k], ok);
        total++;
        if (!ok || vbuf[k] !== g || int'((t_stb[k] - t_d) / 10) !== 100 + exp_lat(1)) begin
            bad++; $display("FAIL refresh_new_wins: got %h want %h", vbuf[k], g);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_div2_pattern();
        test_random();
        test_back_to_back();
        test_reset_mid();
`ifdef LED_TX_AUTO_REFRESH_EN
        test_auto_refresh();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
